// File: rtl/mic_pkg.sv
// Shared definitions for the stereo PDM microphone receiver.
//   PCM_W       : width of each signed PCM output sample
//   mic_state_e : receiver control states
package mic_pkg;

    localparam int unsigned PCM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } mic_state_e;

endpackage

// File: rtl/pdm_decim.sv
// One-channel PDM decimator: counts ones over a frame and converts the
// count c (0..DECIM) to signed PCM = (2c - DECIM) << (15 - log2(DECIM)).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : restart the ones count (frame close or idle)
//   i_smp     : this cycle carries a PDM bit for this channel
//   i_bit     : the PDM bit
//   o_pcm_c   : PCM value for the count including the current bit (comb)
module pdm_decim
    import mic_pkg::*;
#(
    parameter int unsigned DECIM = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_smp,
    input  logic             i_bit,
    output logic [PCM_W-1:0] o_pcm_c
);

    localparam int unsigned K     = $clog2(DECIM);
    localparam int unsigned CW    = K + 1;
    localparam int unsigned SHIFT = PCM_W - 1 - K;

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt;
    logic [PCM_W-1:0] w_diff;

    // Count including the bit arriving this cycle, so the closing sample is part of the frame
    always_comb begin
        w_cnt  = r_cnt + CW'(i_smp & i_bit);
        // Modulo-2^16 arithmetic gives the correct two's complement for c < DECIM
        w_diff = (PCM_W'(w_cnt) << 1) - PCM_W'(DECIM);
        // c == DECIM would be +32768, which saturates
        if (w_cnt == CW'(DECIM)) begin
            o_pcm_c = {1'b0, {(PCM_W-1){1'b1}}};
        end else begin
            o_pcm_c = w_diff << SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt;
        end
    end

endmodule

// File: rtl/mic_pdm_rcv.sv
// Stereo PDM microphone receiver: generates pdm_clk, demultiplexes the
// left (rising toggle) and right (falling toggle) bits, decimates each
// channel by DECIM and presents PCM samples with a one-cycle vld pulse.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : run the microphone interface
//   pdm_data             : stereo PDM bitstream
//   pdm_clk              : microphone clock (registered)
//   lft_chnnl/rght_chnnl : signed PCM samples, held between updates
//   vld                  : both channels updated this cycle
module mic_pdm_rcv
    import mic_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25,
    parameter int unsigned DECIM   = 64,
    parameter int unsigned WARMUP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pdm_data,
    output logic             pdm_clk,
    output logic [PCM_W-1:0] lft_chnnl,
    output logic [PCM_W-1:0] rght_chnnl,
    output logic             vld
);

    localparam int unsigned K     = $clog2(DECIM);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned WU_W  = (WARMUP < 2) ? 1 : $clog2(WARMUP);

    mic_state_e       r_state;
    mic_state_e       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic             r_pdm_clk;
    logic [K-1:0]     r_rcnt;
    logic [WU_W-1:0]  r_wu;
    logic [PCM_W-1:0] r_lft;
    logic [PCM_W-1:0] r_rght;
    logic             r_vld;

    logic             w_wrap;
    logic             w_smp_l;
    logic             w_smp_r;
    logic             w_close;
    logic             w_load;
    logic             w_hold;
    logic             w_clr;
    logic [PCM_W-1:0] w_pcm_l;
    logic [PCM_W-1:0] w_pcm_r;

    // Divider wrap and channel sample strobes; a frame closes on the DECIM-th right bit
    always_comb begin
        w_wrap  = (r_state != ST_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
        w_smp_l = w_wrap && !r_pdm_clk;
        w_smp_r = w_wrap && r_pdm_clk;
        w_close = w_smp_r && (r_rcnt == K'(DECIM - 1));
    end

    // Next state and output-load decision
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_close && (r_wu == WU_W'(WARMUP - 1))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load = w_close;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Idle, or leaving for idle: the datapath is held at zero and any partial frame dropped
    always_comb begin
        w_hold = (r_state == ST_IDLE) || (w_state_nxt == ST_IDLE);
        w_clr  = w_hold || w_close;
    end

    pdm_decim #(.DECIM(DECIM)) u_decim_l (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_smp   (w_smp_l),
        .i_bit   (pdm_data),
        .o_pcm_c (w_pcm_l)
    );

    pdm_decim #(.DECIM(DECIM)) u_decim_r (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_smp   (w_smp_r),
        .i_bit   (pdm_data),
        .o_pcm_c (w_pcm_r)
    );

    // State, divider, frame counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_pdm_clk <= 1'b0;
            r_rcnt    <= '0;
            r_wu      <= '0;
            r_lft     <= '0;
            r_rght    <= '0;
            r_vld     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hold) begin
                r_div     <= '0;
                r_pdm_clk <= 1'b0;
                r_rcnt    <= '0;
                r_wu      <= '0;
            end else begin
                r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
                if (w_wrap) begin
                    r_pdm_clk <= !r_pdm_clk;
                end
                if (w_smp_r) begin
                    r_rcnt <= w_close ? '0 : r_rcnt + K'(1);
                end
                if (w_close && (r_state == ST_WARMUP)) begin
                    r_wu <= r_wu + WU_W'(1);
                end
            end
            r_vld <= w_load;
            if (w_load) begin
                r_lft  <= w_pcm_l;
                r_rght <= w_pcm_r;
            end
        end
    end

    assign pdm_clk    = r_pdm_clk;
    assign lft_chnnl  = r_lft;
    assign rght_chnnl = r_rght;
    assign vld        = r_vld;

endmodule

// File: doc/mic_pdm_rcv.md
MIC_PDM_RCV -- requirements
Module: mic_pdm_rcv

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, meaning clk cycles per pdm_clk half-period (legal range >=2).
REQ-002 SHALL have parameter DECIM, default 64, meaning PDM bits per channel per output sample (power of two, 16..1024; K = log2(DECIM)).
REQ-003 SHALL have parameter WARMUP, default 16, meaning output frames discarded after enable (legal range >=0).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  enable; 1 = run the microphone interface.
REQ-007 SHALL have port pdm_data  input  1  stereo PDM bitstream from the microphone pair.
REQ-008 SHALL have port pdm_clk  output  1  microphone clock, registered.
REQ-009 SHALL have port lft_chnnl  output  16  signed left PCM sample, held between updates.
REQ-010 SHALL have port rght_chnnl  output  16  signed right PCM sample, held between updates.
REQ-011 SHALL have port vld  output  1  one-cycle pulse: both channel outputs updated this cycle.

Function
REQ-012 SHALL run a divider counter 0..CLK_DIV-1 while running; on each wrap, toggle pdm_clk.
REQ-013 SHALL sample pdm_data into the left channel on the wrap cycle while pdm_clk=0 (rising toggle), and into the right channel on the wrap cycle while pdm_clk=1 (falling toggle).
REQ-014 SHALL count ones per channel over DECIM samples; count c ranges 0..DECIM.
REQ-015 SHALL convert each count to PCM = (2c - DECIM) << (15-K); +32768 SHALL saturate to 0x7FFF, -32768 = 0x8000 exactly.
REQ-016 SHALL close a frame on the DECIM-th right sample, that sample included; the next cycle both outputs load and vld=1 for exactly one cycle.
REQ-017 SHALL restart both counters at frame close with no lost or duplicated bits; vld period = 2*CLK_DIV*DECIM cycles in steady state.
REQ-018 SHALL implement FSM IDLE/WARMUP/RUN: IDLE holds pdm_clk=0, divider and counters at 0, vld=0.
REQ-019 SHALL move IDLE->WARMUP when en=1 (or IDLE->RUN if WARMUP=0); divider starts from 0 on the next cycle.
REQ-020 SHALL in WARMUP compute frames but suppress vld and output loads; after WARMUP frames close, go to RUN.
REQ-021 SHALL in RUN load outputs and pulse vld per REQ-016.
REQ-022 SHALL on en=0 in any state go to IDLE next cycle, abandon the partial frame, force pdm_clk=0, and keep lft_chnnl/rght_chnnl at last values.
REQ-023 SHALL, if en falls on a frame-close cycle, suppress that frame's vld and output loads.

Reset
REQ-024 SHALL on rst=1 at a clk edge set state=IDLE, pdm_clk=0, lft_chnnl=0, rght_chnnl=0, vld=0, and divider, counters and warmup count to 0.
REQ-025 SHALL give rst priority over en; reset mid-frame discards the frame with no vld.

Structure
REQ-026 SHALL place the state enum (IDLE, WARMUP, RUN) and the PCM width constant (16) in shared package mic_pkg.
REQ-027 SHALL use one sub-module pdm_decim (ones counter plus conversion/saturation), instanced once per channel; divider and FSM stay in mic_pdm_rcv.

Verification (CLK_DIV=2, DECIM=16, WARMUP=1)
REQ-028 SHALL check: pdm_data=1 constant, en=1 -> first vld after the warmup frame, lft=rght=0x7FFF, subsequent vld every 64 clk cycles.
REQ-029 SHALL check: pdm_data=0 constant -> lft=rght=0x8000 on each vld.
REQ-030 SHALL check: pdm_data=1 at left samples, 0 at right samples -> lft=0x7FFF, rght=0x8000.
REQ-031 SHALL check: ones on 8 of 16 samples per channel -> lft=rght=0x0000; 12 of 16 -> 0x4000.
REQ-032 SHALL check: en dropped mid-frame -> pdm_clk=0 next cycle, no vld, outputs hold; en re-raised -> warmup frame repeats before the next vld.
REQ-033 SHALL check: rst=1 mid-frame in RUN -> all outputs 0 next cycle, no vld until the full warmup sequence completes.
